memctrl: RTL

Single-port memory controller and arbiter between instruction fetch and the load/store buffer. It owns the byte-wide RAM/IO port and serialises 1/2/4-byte reads and writes into per-byte RAM cycles. When both requesters are pending it grants the port round-robin. On a pipeline flush it aborts speculative traffic (fetches and loads) and always completes committed stores.

---
 rtl/memctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/memctrl.sv
// Single-port byte-wide memory controller arbitrating between instruction fetch and the load/store buffer.
// Multi-byte accesses are serialised into one RAM cycle per byte; reads are abortable on flush, stores are not.
module memctrl #(
  parameter int         BYTE_CNT_W = 3,
  parameter logic [1:0] IO_HI      = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  width,
  input  logic [31:0] store_val,
  output logic        ls_finished,
  output logic [31:0] read_val,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                state, state_next;
  logic                  owner_lsb, last_grant_lsb, mem_wr_q;
  logic [31:0]           base, asm_q;
  logic [BYTE_CNT_W-1:0] n, issue_idx, cap_idx;

  logic                  lsb_pend, grant_lsb, grant_if, take_grant, req_write;
  logic                  io_stall_new, io_stall, read_last, write_last;
  logic [31:0]           req_addr, read_word;
  logic [BYTE_CNT_W-1:0] req_n, n_last, next_idx;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in)
      state <= IDLE;
    else if (rdy_in)
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_grant) state_next = req_write ? WRITE : READ;
      READ:    if (clear || read_last) state_next = IDLE;
      WRITE:   if (write_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Round-robin: on contention the requester that did not win last time gets the port.
  always_comb begin
    lsb_pend     = re | we;
    grant_lsb    = lsb_pend & (~if_req | ~last_grant_lsb);
    grant_if     = if_req & ~grant_lsb;
    take_grant   = (state == IDLE) & ~clear & (grant_lsb | grant_if);
    req_write    = grant_lsb & we;
    req_addr     = grant_if ? if_addr : addr;
    if (grant_if || width[1])
      req_n = BYTE_CNT_W'(4);
    else if (width[0])
      req_n = BYTE_CNT_W'(2);
    else
      req_n = BYTE_CNT_W'(1);
    io_stall_new = io_buffer_full & (req_addr[17:16] == IO_HI);
    io_stall     = io_buffer_full & (base[17:16] == IO_HI);
    n_last       = n - BYTE_CNT_W'(1);
    read_last    = (state == READ) & (cap_idx == n_last);
    write_last   = (state == WRITE) & mem_wr_q & (issue_idx == n_last);
    next_idx     = issue_idx + BYTE_CNT_W'(1);
    read_word    = asm_q;
    read_word[{cap_idx[1:0], 3'b000} +: 8] = mem_din;
  end

  assign mem_wr = mem_wr_q & rdy_in;

  // A write slot is only driven when the IO buffer can take it; a stalled slot is retried in place.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      mem_a          <= '0;
      mem_dout       <= '0;
      mem_wr_q       <= 1'b0;
      if_done        <= 1'b0;
      if_data        <= '0;
      ls_finished    <= 1'b0;
      read_val       <= '0;
      last_grant_lsb <= 1'b0;
      owner_lsb      <= 1'b0;
      base           <= '0;
      asm_q          <= '0;
      n              <= '0;
      issue_idx      <= '0;
      cap_idx        <= '0;
    end else if (rdy_in) begin
      if_done     <= 1'b0;
      ls_finished <= 1'b0;
      case (state)
        IDLE: begin
          if (take_grant) begin
            owner_lsb <= grant_lsb;
            base      <= req_addr;
            n         <= req_n;
            mem_a     <= req_addr;
            cap_idx   <= '0;
            asm_q     <= '0;
            if (req_write) begin
              issue_idx <= '0;
              mem_dout  <= store_val[7:0];
              mem_wr_q  <= ~io_stall_new;
            end else begin
              issue_idx <= BYTE_CNT_W'(1);
            end
          end
        end
        READ: begin
          if (!clear) begin
            asm_q <= read_word;
            if (read_last) begin
              last_grant_lsb <= owner_lsb;
              if (owner_lsb) begin
                read_val    <= read_word;
                ls_finished <= 1'b1;
              end else begin
                if_data <= read_word;
                if_done <= 1'b1;
              end
            end else begin
              cap_idx <= cap_idx + BYTE_CNT_W'(1);
              if (issue_idx < n) begin
                mem_a     <= base + 32'(issue_idx);
                issue_idx <= next_idx;
              end
            end
          end
        end
        WRITE: begin
          if (mem_wr_q) begin
            if (write_last) begin
              mem_wr_q       <= 1'b0;
              ls_finished    <= 1'b1;
              last_grant_lsb <= 1'b1;
            end else begin
              issue_idx <= next_idx;
              mem_a     <= base + 32'(next_idx);
              mem_dout  <= store_val[{next_idx[1:0], 3'b000} +: 8];
              mem_wr_q  <= ~io_stall;
            end
          end else if (!io_stall) begin
            mem_wr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
